// File: rtl/led_seq_core_pkg.sv
// Shared definitions for the LED CPU execution core.
//  - Opcode constants (OP_NOP..OP_HALT), also used by the programming-logic
//    testbench so both sides agree on the instruction set.
//  - FSM state encoding of the core.
//  - Field positions of a program word: opcode = [15:8], operand = [7:0].
package led_seq_core_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LED  = 8'h01;
  localparam logic [7:0] OP_XOR  = 8'h02;
  localparam logic [7:0] OP_WAIT = 8'h03;
  localparam logic [7:0] OP_JMP  = 8'h04;
  localparam logic [7:0] OP_HALT = 8'h05;

  // Field widths of a program word {opcode, operand}.
  localparam int OPC_W = 8;
  localparam int OPR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    WAIT   = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/led_seq_core_if.sv
// Signal bundle between the LED CPU core and its surroundings.
//  run      : level start/stop request from the board
//  rd_addr  : program RAM read address (equals the core's PC)
//  rd_data  : program RAM read data
//  led      : the 8 board LEDs
//  busy     : core is in FETCH, DECODE or WAIT
//  halted   : core is in HALT
//  state    : current FSM state, for observation only
// Read port timing: there is no valid/ready pair. The RAM is synchronous;
// rd_data is the word at the rd_addr presented on the previous rising edge,
// i.e. it is valid exactly one cycle after rd_addr, with no back-pressure.
// The core holds rd_addr stable through FETCH so the word is ready in DECODE.
interface led_seq_core_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  import led_seq_core_pkg::*;

  logic              run;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        led;
  logic              busy;
  logic              halted;
  state_t            state;

  // master: the core side (drives the RAM address and the LEDs)
  modport master (
    input  run, rd_data,
    output rd_addr, led, busy, halted, state
  );

  // slave: the RAM / board side
  modport slave (
    output run, rd_data,
    input  rd_addr, led, busy, halted, state
  );
endinterface

// File: rtl/led_seq_core_prescaler.sv
// led_tick_prescaler: divides clk down to one-cycle WAIT ticks.
//  clk  in  system clock
//  rst  in  synchronous, active-high reset
//  clr  in  restart the count at 0 (takes priority over en)
//  en   in  count while high; hold otherwise
//  tick out high on the cycle the count is at TICK_DIV-1 while en is high;
//           the count wraps to 0 on that edge, so ticks are TICK_DIV apart.
module led_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  // Keep at least one bit so TICK_DIV == 1 (tick every enabled cycle) works.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (tick) cnt_q <= '0;
      else      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/led_seq_core.sv
// led_seq_core: execution core of the LED CPU.
// Fetches 16-bit words {opcode, operand} from a synchronous program RAM,
// executes them and drives the 8 board LEDs. Each non-WAIT instruction takes
// FETCH + DECODE = 2 cycles; WAIT n stays in WAIT for n*TICK_DIV cycles.
// Ports:
//  clk  in  system clock, all state on the rising edge
//  rst  in  synchronous, active-high reset (overrides everything)
//  bus  led_seq_core_if.master: run, rd_addr, rd_data, led, busy, halted, state
module led_seq_core
  import led_seq_core_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 50000
) (
  input logic            clk,
  input logic            rst,
  led_seq_core_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        led_q, led_d;
  logic [7:0]        wait_q, wait_d;
  logic              run_q;
  logic              armed_q;
  logic              presc_clr;
  logic              presc_en;
  logic              tick;
  logic              start;
  logic [OPC_W-1:0]  opcode;
  logic [OPR_W-1:0]  operand;

  assign opcode  = bus.rd_data[DATA_W-1 -: OPC_W];
  assign operand = bus.rd_data[OPR_W-1:0];

  // A start is a rising edge of run. armed_q is set once run has been seen
  // low after reset, so holding run high through a reset never launches the
  // program on its own; a fresh rising edge is always required.
  assign start = bus.run && !run_q && armed_q;

  // The prescaler only advances in WAIT; it is zeroed on WAIT entry so the
  // first tick lands exactly TICK_DIV cycles later.
  assign presc_en = (state_q == WAIT) && bus.run;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      led_q   <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      led_q   <= led_d;
      wait_q  <= wait_d;
      run_q   <= bus.run;
      if (!bus.run) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    led_d     = led_q;
    wait_d    = wait_q;
    presc_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end

      // rd_addr already equals pc; this cycle covers the RAM latency.
      FETCH: begin
        if (!bus.run) state_d = IDLE;
        else          state_d = DECODE;
      end

      DECODE: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = FETCH;
          case (opcode)
            OP_LED: led_d = operand;
            OP_XOR: led_d = led_q ^ operand;
            OP_WAIT: begin
              // WAIT 0 falls through as a NOP.
              if (operand != '0) begin
                wait_d    = operand;
                presc_clr = 1'b1;
                state_d   = WAIT;
              end
            end
            OP_JMP: pc_d = ADDR_W'(operand);
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = HALT;
            end
            default: ; // NOP and undefined opcodes
          endcase
        end
      end

      WAIT: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (tick) begin
          wait_d = wait_q - 8'd1;
          if (wait_q == 8'd1) state_d = FETCH;
        end
      end

      HALT: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_addr = pc_q;
  assign bus.led     = led_q;
  assign bus.busy    = (state_q == FETCH) || (state_q == DECODE) || (state_q == WAIT);
  assign bus.halted  = (state_q == HALT);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_led_seq_core.sv
// Directed testbench for led_seq_core with a 1-cycle-latency program RAM
// model and TICK_DIV = 4.
module tb_led_seq_core;
  import led_seq_core_pkg::*;

  localparam int TICK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_seq_core_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  led_seq_core #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Synchronous program RAM: data appears one cycle after the address.
  logic [15:0] mem [256];
  always_ff @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges and settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.run = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic start_run();
    bus.run = 1'b1;
    cyc(1);
  endtask

  task automatic wait_state(input state_t s, input int max, input string tag);
    int n = 0;
    while (bus.state !== s && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(bus.state === s), 32'd1);
  endtask

  logic [7:0] seq5 [8];
  logic [7:0] prev;
  logic [7:0] cur;
  int n;
  int bad;

  initial begin
    bus.run = 1'b0;
    fill({OP_HALT, 8'h00});

    // ---- 1: reset ----
    rst = 1'b1;
    cyc(3);
    chk("t1_led",     32'(bus.led),     32'h00);
    chk("t1_busy",    32'(bus.busy),    32'd0);
    chk("t1_halted",  32'(bus.halted),  32'd0);
    chk("t1_rd_addr", 32'(bus.rd_addr), 32'h00);
    chk("t1_state",   32'(bus.state),   32'(IDLE));
    rst = 1'b0;
    cyc(1);

    // ---- 2: LED, XOR, HALT ----
    fill({OP_HALT, 8'h00});
    mem[0] = 16'h01A5;
    mem[1] = 16'h0205;
    mem[2] = 16'h0500;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA0);
    start_run();
    chk("t2_start_fetch", 32'(bus.state), 32'(FETCH));
    prev = bus.led;
    n = 0;
    while (!bus.halted && n < 30) begin
      cyc(1);
      n++;
      if (bus.led !== prev) begin
        if (exp_q.size() == 0) chk("t2_extra_led", 32'(bus.led), 32'(prev));
        else                   chk("t2_led", 32'(bus.led), 32'(exp_q.pop_front()));
        prev = bus.led;
      end
    end
    chk("t2_all_leds_seen", 32'(exp_q.size()), 32'd0);
    chk("t2_halted",  32'(bus.halted),  32'd1);
    chk("t2_state",   32'(bus.state),   32'(HALT));
    chk("t2_pc",      32'(bus.rd_addr), 32'h02);
    chk("t2_busy",    32'(bus.busy),    32'd0);
    chk("t2_cycles",  32'(n),           32'd6);
    cyc(3);
    chk("t2_no_restart", 32'(bus.state), 32'(HALT));
    chk("t2_led_final",  32'(bus.led),   32'hA0);
    exp_q.delete();

    // ---- 3: WAIT 2 ticks = 8 cycles ----
    do_reset();
    fill({OP_HALT, 8'h00});
    mem[0] = 16'h0103;
    mem[1] = 16'h0302;
    mem[2] = 16'h010C;
    mem[3] = 16'h0500;
    start_run();
    wait_state(WAIT, 10, "t3_reach_wait");
    chk("t3_led_in_wait", 32'(bus.led), 32'h03);
    n = 0;
    bad = 0;
    while (bus.state === WAIT && n < 50) begin
      if (bus.led !== 8'h03) bad++;
      if (bus.busy !== 1'b1) bad++;
      n++;
      cyc(1);
    end
    chk("t3_wait_cycles", 32'(n),           32'd8);
    chk("t3_wait_held",   32'(bad),         32'd0);
    chk("t3_after_wait",  32'(bus.state),   32'(FETCH));
    chk("t3_pc_after",    32'(bus.rd_addr), 32'h02);
    wait_state(HALT, 10, "t3_reach_halt");
    chk("t3_led_0c", 32'(bus.led), 32'h0C);
    // Stop and restart from address 0.
    bus.run = 1'b0;
    cyc(1);
    chk("t3_stop_idle", 32'(bus.state), 32'(IDLE));
    chk("t3_stop_led",  32'(bus.led),   32'h0C);
    bus.run = 1'b1;
    cyc(1);
    chk("t3_restart_state", 32'(bus.state),   32'(FETCH));
    chk("t3_restart_pc",    32'(bus.rd_addr), 32'h00);
    cyc(2);
    chk("t3_restart_led",   32'(bus.led),     32'h03);

    // ---- 4: JMP loop toggling LEDs, then stop ----
    do_reset();
    fill({OP_HALT, 8'h00});
    mem[0] = 16'h0401;
    mem[1] = 16'h0255;
    mem[2] = 16'h0401;
    start_run();
    n = 0;
    while (bus.led !== 8'h55 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("t4_first_55", 32'(bus.led), 32'h55);
    cur = 8'h55;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) begin
        cyc(1);
        if (k == 4) cur = cur ^ 8'h55;
        chk("t4_toggle", 32'(bus.led), 32'(cur));
      end
    end
    bus.run = 1'b0;
    cyc(1);
    chk("t4_stop_idle", 32'(bus.state), 32'(IDLE));
    chk("t4_stop_busy", 32'(bus.busy),  32'd0);
    chk("t4_stop_led",  32'(bus.led),   32'h55);
    cyc(3);
    chk("t4_frozen_led",   32'(bus.led),   32'h55);
    chk("t4_frozen_state", 32'(bus.state), 32'(IDLE));

    // ---- 5: all NOPs, PC wrap ----
    do_reset();
    fill({OP_NOP, 8'h00});
    start_run();
    n = 0;
    while (bus.rd_addr !== 8'hFE && n < 600) begin
      cyc(1);
      n++;
    end
    chk("t5_reach_fe", 32'(bus.rd_addr), 32'hFE);
    chk("t5_fe_fetch", 32'(bus.state),   32'(FETCH));
    seq5 = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 8; i++) begin
      chk("t5_rd_addr", 32'(bus.rd_addr), 32'(seq5[i]));
      chk("t5_busy",    32'(bus.busy),    32'd1);
      cyc(1);
    end

    // ---- 6: reset in the middle of a long WAIT ----
    do_reset();
    fill({OP_HALT, 8'h00});
    mem[0] = 16'h0181;
    mem[1] = 16'h03FF;
    start_run();
    wait_state(WAIT, 10, "t6_reach_wait");
    chk("t6_led_before", 32'(bus.led), 32'h81);
    cyc(5);
    chk("t6_still_wait", 32'(bus.state), 32'(WAIT));
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_state",   32'(bus.state),   32'(IDLE));
    chk("t6_rst_led",     32'(bus.led),     32'h00);
    chk("t6_rst_busy",    32'(bus.busy),    32'd0);
    chk("t6_rst_rd_addr", 32'(bus.rd_addr), 32'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t6_hold_idle", 32'(bus.state), 32'(IDLE));
    end
    bus.run = 1'b0;
    cyc(1);
    bus.run = 1'b1;
    cyc(1);
    chk("t6_fresh_edge", 32'(bus.state), 32'(FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against any unforeseen stall.
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
